uart_msg_rx: RTL and testbench
==============================

# uart_msg_rx

Receive-side partner of the button-triggered UART message sender. Deserialises 8N1 UART frames from a single serial input line into bytes. Assembles a fixed-length message with the first received byte placed in the most significant byte. Optionally compares the completed message against the expected constant. Sits between the board RX pin and the status LEDs / downstream logic.

## Interface
Parameters:
- `CLK_DIV`, 2604: clock cycles per bit (25 MHz / 9600 baud); legal range ≥ 4.
- `LENGTH`, 11: message length in bytes.
- `EXPECT`, 88'h69206C696B652046504741: expected message ("i like FPGA"), `LENGTH*8` bits, first byte in bits [LENGTH*8-1 -: 8].

Ports:
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `uart_rx` input 1: asynchronous serial line, idle high.
- `clear` input 1: synchronous message restart; discards partial message.
- `rx_byte` output 8: last good byte.
- `rx_valid` output 1: one-cycle pulse when `rx_byte` is updated.
- `frame_err` output 1: one-cycle pulse on bad stop bit.
- `msg_data` output LENGTH*8: assembled message; holds after completion.
- `msg_done` output 1: one-cycle pulse when the LENGTH-th byte is stored.
- `msg_match` output 1: level; high while the last completed message equals `EXPECT`.

## Operation
- Input path: 2-FF synchroniser on `uart_rx`, plus one more register for falling-edge detection. Synchroniser flops reset to 1.
- Bit FSM states:
  - IDLE: on a synchronised falling edge → START; load the bit timer with CLK_DIV/2 − 1.
  - START: at timer expiry, sample the line.
    - Low → DATA; bit index 0; timer reloaded to CLK_DIV − 1.
    - High → IDLE (glitch rejection; no output).
  - DATA: sample at each expiry, LSB first, into a shift register. After bit 7 → STOP.
  - STOP: sample at expiry.
    - High → pulse `rx_valid`, update `rx_byte` → IDLE.
    - Low → pulse `frame_err` → BREAK.
  - BREAK: wait until the synchronised line is high → IDLE.
- Message assembly:
  - Byte counter `cnt` runs 0..LENGTH−1.
  - Each good byte is written to `msg_data[(LENGTH-1-cnt)*8 +: 8]`.
  - On `cnt == LENGTH-1`: pulse `msg_done`, update `msg_match`, wrap `cnt` to 0.
  - `msg_data` keeps its old content in bytes not yet overwritten by the next message.
- `frame_err` resets `cnt` to 0 (partial message abandoned). It does not change `msg_match`.
- `clear`:
  - Resets `cnt` to 0 and clears `msg_match`.
  - Does not disturb the bit FSM; a byte completing in the same cycle is counted as byte 0 of the new message.
- `rst`: all outputs 0, `msg_data` 0, FSM IDLE, `cnt` 0.

## Timing
- Sampling instants: CLK_DIV/2 cycles after the synchronised falling edge, then every CLK_DIV cycles (integer division; CLK_DIV/2 floors).
- `rx_valid`/`frame_err` assert on the cycle after the stop-bit sample point. Total delay from the start edge at the pin is 2 sync + CLK_DIV/2 + 9·CLK_DIV + 1 cycles.
- `msg_done` and the `msg_match` update coincide with the final byte's `rx_valid`.
- Earliest restart: a new falling edge is accepted on the first cycle back in IDLE. Back-to-back frames with one stop bit are received without loss.
- Bit timer width `$clog2(CLK_DIV)`; byte counter width `$clog2(LENGTH)`, minimum 1.
- Reset mid-frame: the next cycle is IDLE; a line still low is ignored until a new falling edge.

## Configuration
- `UART_MSG_MATCH_EN` defined: the comparator against `EXPECT` is built and `msg_match` behaves as specified.
- `UART_MSG_MATCH_EN` not defined: no comparator is built; `msg_match` is tied to 0. `msg_done` and `msg_data` are unchanged.

## Structure
- Shared package `uart_pkg`: bit-FSM state enum (IDLE, START, DATA, STOP, BREAK), default `CLK_DIV`, default message constant, and message length 11. The same constants are used by the sender.
- Sub-module `uart_rx_byte`: synchroniser, bit FSM and bit timer. Outputs `rx_byte`, `rx_valid` and `frame_err`.
- Top level: message counter, assembly register and comparator.

## Test plan
- Single byte 8'h41 at CLK_DIV=16 → one `rx_valid`, `rx_byte`=8'h41, exactly 2+8+144+1 cycles after the start edge.
- Full "i like FPGA" back-to-back → `msg_done` once with the 11th `rx_valid`; `msg_data`=EXPECT; `msg_match`=1.
- Message with last byte 8'h42 → `msg_done`=1, `msg_match`=0; with the macro undefined, `msg_match`=0 always.
- 3-cycle low glitch on idle line → no `rx_valid`, no `frame_err`, FSM back in IDLE.
- Stop bit forced low on byte 5, line held low 40 cycles → `frame_err` pulse; no `rx_valid` until the line goes high and a new start arrives. Then a full 11 bytes → `msg_done` with correct data.
- `rst` asserted mid-DATA, then a fresh frame 8'h69 → `rx_valid` with 8'h69; `cnt` restarted. `clear` after 4 bytes, then 11 bytes → one `msg_done`, match=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver bit-FSM state type, common to sender and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int unsigned DEF_CLK_DIV = 2604;
  localparam int unsigned MSG_LEN     = 11;
  localparam logic [MSG_LEN*8-1:0] DEF_MSG = 88'h69206C696B652046504741;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, bit timer and bit FSM.
// The *_c outputs are next-cycle strobes so the message logic can update in step with rx_valid.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [7:0] byte_c,
  output logic       byte_done_c,
  output logic       frame_err_c
);

  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] HALF_LD = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] BIT_LD  = TW'(CLK_DIV - 1);

  rx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, sync2_q, prev_q;
  logic          fall_c, expire_c;

  assign fall_c   = prev_q & ~sync2_q;
  assign expire_c = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= ST_IDLE;
      timer_q <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      byte_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit FSM: every timed state counts down and acts on the sample at expiry.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if ((state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) && !expire_c) begin
      timer_d = timer_q - TW'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (fall_c) begin
          state_d = ST_START;
          timer_d = HALF_LD;
        end
      end
      ST_START: begin
        if (expire_c) begin
          if (!sync2_q) begin
            state_d = ST_DATA;
            bit_d   = 3'd0;
            timer_d = BIT_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (expire_c) begin
          shift_d = {sync2_q, shift_q[7:1]};
          timer_d = BIT_LD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (expire_c) begin
          if (sync2_q) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (sync2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_byte     = byte_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign byte_c      = shift_q;
  assign byte_done_c = valid_d;
  assign frame_err_c = ferr_d;

endmodule

// File: rtl/uart_msg_rx.sv
// UART message receiver: assembles LENGTH bytes (first byte in the MSB) from an 8N1 line.
// Define UART_MSG_MATCH_EN to build the comparator against EXPECT; otherwise msg_match is 0.
module uart_msg_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned LENGTH  = MSG_LEN,
  parameter logic [LENGTH*8-1:0] EXPECT = DEF_MSG
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rx,
  input  logic                clear,
  output logic [7:0]          rx_byte,
  output logic                rx_valid,
  output logic                frame_err,
  output logic [LENGTH*8-1:0] msg_data,
  output logic                msg_done,
  output logic                msg_match
);

  localparam int unsigned MW = LENGTH * 8;
  localparam int unsigned CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  logic [7:0]    byte_c;
  logic          byte_done_c, frame_err_c;
  logic [CW-1:0] cnt_q, cnt_d, idx_c;
  logic [MW-1:0] msg_q, msg_d;
  logic          done_q, done_d;

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .byte_c      (byte_c),
    .byte_done_c (byte_done_c),
    .frame_err_c (frame_err_c)
  );

  // A clear in the same cycle as a completing byte makes that byte slot 0.
  always_comb begin
    cnt_d  = cnt_q;
    msg_d  = msg_q;
    done_d = 1'b0;
    idx_c  = clear ? '0 : cnt_q;
    if (clear || frame_err_c) cnt_d = '0;
    if (byte_done_c) begin
      for (int unsigned b = 0; b < LENGTH; b++) begin
        if (idx_c == CW'(LENGTH - 1 - b)) msg_d[b*8 +: 8] = byte_c;
      end
      if (idx_c == CW'(LENGTH - 1)) begin
        done_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = idx_c + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      msg_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      msg_q  <= msg_d;
      done_q <= done_d;
    end
  end

  assign msg_data = msg_q;
  assign msg_done = done_q;

`ifdef UART_MSG_MATCH_EN
  logic match_q, match_d;

  always_comb begin
    match_d = match_q;
    if (clear) match_d = 1'b0;
    if (done_d) match_d = (msg_d == EXPECT);
  end

  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match_d;
  end

  assign msg_match = match_q;
`else
  logic unused_expect;
  assign unused_expect = ^EXPECT;
  assign msg_match     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_msg_rx.sv
// Directed bench for uart_msg_rx with a frame-level event model checked every cycle.
module tb_uart_msg_rx;

  localparam int D   = 16;
  localparam int LAT = 2 + D / 2 + 9 * D + 1;
  localparam logic [87:0] MSG_OK  = 88'h69206C696B652046504741;
  localparam logic [87:0] MSG_BAD = 88'h69206C696B652046504742;
`ifdef UART_MSG_MATCH_EN
  localparam logic EXP_M = 1'b1;
`else
  localparam logic EXP_M = 1'b0;
`endif

  typedef struct {
    int         due;
    bit         good;
    logic [7:0] b;
  } ev_t;

  logic        clk, rst, uart_rx, clear;
  logic [7:0]  rx_byte;
  logic        rx_valid, frame_err, msg_done, msg_match;
  logic [87:0] msg_data;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   lat;
  ev_t  evq[$];

  uart_msg_rx #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .clear     (clear),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .msg_data  (msg_data),
    .msg_done  (msg_done),
    .msg_match (msg_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: a frame started at cycle s yields its pulse at cycle s+LAT; message rules applied per event.
  logic [87:0] m_msg = '0;
  logic [7:0]  m_byte = '0;
  int          m_cnt = 0;
  logic        m_match = 1'b0;
  logic        r, c, e_v, e_fe, e_done;
  ev_t         ev;

  always begin
    @(posedge clk);
    cyc++;
    r = rst;
    c = clear;
    @(negedge clk);
    e_v = 1'b0; e_fe = 1'b0; e_done = 1'b0;
    if (r) begin
      m_msg = '0; m_byte = '0; m_cnt = 0; m_match = 1'b0;
    end else begin
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev = evq.pop_front();
        if (ev.good) begin e_v = 1'b1; m_byte = ev.b; end
        else e_fe = 1'b1;
      end
      if (c) begin m_cnt = 0; m_match = 1'b0; end
      if (e_fe) m_cnt = 0;
      if (e_v) begin
        m_msg[(10 - m_cnt) * 8 +: 8] = m_byte;
        if (m_cnt == 10) begin
          e_done  = 1'b1;
          m_cnt   = 0;
          m_match = EXP_M & (m_msg == MSG_OK);
        end else begin
          m_cnt++;
        end
      end
    end
    if (msg_done === 1'b1) n_done++;
    chk("rx_valid",  88'(rx_valid),  88'(e_v));
    chk("frame_err", 88'(frame_err), 88'(e_fe));
    chk("rx_byte",   88'(rx_byte),   88'(m_byte));
    chk("msg_done",  88'(msg_done),  88'(e_done));
    chk("msg_match", 88'(msg_match), 88'(m_match));
    chk("msg_data",  msg_data,       m_msg);
  end

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit push);
    ev_t e;
    @(posedge clk); #1;
    uart_rx = 1'b0;
    if (push) begin
      e.due = cyc + LAT; e.good = stop_ok; e.b = b;
      evq.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (D) @(posedge clk); #1;
      uart_rx = b[i];
    end
    repeat (D) @(posedge clk); #1;
    uart_rx = stop_ok;
    repeat (D - 1) @(posedge clk);
  endtask

  task automatic send_msg(input logic [87:0] m, input int first, input int last);
    logic [87:0] mm;
    mm = m;
    for (int k = first; k <= last; k++) send_frame(mm[87 - 8 * k -: 8], 1'b1, 1'b1);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("reset_msg_data", msg_data, 88'h0);
    chk("reset_rx_byte", 88'(rx_byte), 88'h0);

    // Single byte, explicit latency from the pin edge
    fork
      send_frame(8'h41, 1'b1, 1'b1);
      begin
        lat = 0;
        @(posedge clk);
        for (int i = 0; i < 300; i++) begin
          @(posedge clk); lat++; #1;
          if (rx_valid === 1'b1) break;
        end
      end
    join
    chk("latency_41", 88'(lat), 88'd155);
    chk("byte_41", 88'(rx_byte), 88'h41);
    repeat (5) @(posedge clk);
    pulse_clear();

    // Short low glitch on an idle line
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (3) @(posedge clk); #1 uart_rx = 1'b1;
    repeat (30) @(posedge clk);

    send_msg(MSG_OK, 0, 10);
    repeat (5) @(posedge clk); #1;
    chk("ok_msg_data", msg_data, 88'h69206C696B652046504741);
    chk("ok_msg_match", 88'(msg_match), 88'(EXP_M));

    // Bad stop bit on byte 5, line held low, then a full message
    send_msg(MSG_OK, 0, 3);
    send_frame(8'h6B, 1'b0, 1'b1);
    repeat (40) @(posedge clk); #1 uart_rx = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("ferr_match_kept", 88'(msg_match), 88'(EXP_M));
    send_msg(MSG_OK, 0, 10);

    send_msg(MSG_BAD, 0, 10);
    repeat (5) @(posedge clk); #1;
    chk("bad_msg_data", msg_data, 88'h69206C696B652046504742);
    chk("bad_msg_match", 88'(msg_match), 88'h0);

    // Reset while the receiver is in the data bits
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (D) @(posedge clk); #1 uart_rx = 1'b1;
    repeat (30) @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (200) @(posedge clk); #1;
    chk("rst_msg_data", msg_data, 88'h0);
    send_frame(8'h69, 1'b1, 1'b1);
    chk("rst_fresh_byte", 88'(rx_byte), 88'h69);
    send_msg(MSG_OK, 1, 10);

    // Clear after four bytes
    send_msg(MSG_BAD, 0, 3);
    repeat (5) @(posedge clk);
    pulse_clear();
    send_msg(MSG_OK, 0, 10);

    // Clear coinciding with a completing byte: that byte becomes byte 0
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1);
    fork
      send_frame(8'h69, 1'b1, 1'b1);
      begin
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
      end
    join
    send_msg(MSG_OK, 1, 10);
    repeat (20) @(posedge clk); #1;
    chk("final_msg_data", msg_data, 88'h69206C696B652046504741);
    chk("done_count", 88'(n_done), 88'd6);
    chk("events_drained", 88'(evq.size()), 88'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
